// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the three requesters, the decode-stage hazard probe
// and the register-file write port.
// Optional forwarding data (qa_data/qb_data) exists only when RF_ARB_FWD_EN is defined.
interface rf_write_arbiter_if;
    // ALU writeback request
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    // Load writeback request
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    // Link (return address into r31) request
    logic        lnk_valid;
    logic        lnk_ready;
    logic [31:0] lnk_pc;
    // Read-port hazard probe
    logic [4:0]  qa_reg;
    logic [4:0]  qb_reg;
    logic        qa_hit;
    logic        qb_hit;
`ifdef RF_ARB_FWD_EN
    logic [31:0] qa_data;
    logic [31:0] qb_data;
`endif
    // Register-file write port
    logic        RegWr;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;

`ifdef RF_ARB_FWD_EN
    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output lnk_valid, lnk_pc,
        output qa_reg, qb_reg,
        input  alu_ready, mem_ready, lnk_ready,
        input  qa_hit, qb_hit, qa_data, qb_data,
        input  RegWr, WriteReg, WriteData
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  lnk_valid, lnk_pc,
        input  qa_reg, qb_reg,
        output alu_ready, mem_ready, lnk_ready,
        output qa_hit, qb_hit, qa_data, qb_data,
        output RegWr, WriteReg, WriteData
    );
`else
    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output lnk_valid, lnk_pc,
        output qa_reg, qb_reg,
        input  alu_ready, mem_ready, lnk_ready,
        input  qa_hit, qb_hit,
        input  RegWr, WriteReg, WriteData
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  lnk_valid, lnk_pc,
        input  qa_reg, qb_reg,
        output alu_ready, mem_ready, lnk_ready,
        output qa_hit, qb_hit,
        output RegWr, WriteReg, WriteData
    );
`endif
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port among the ALU,
// load and link writeback requesters. Each requester owns a DEPTH-entry FIFO.
// The FIFOs are drained round-robin, one write per cycle, through a registered
// output stage. Pending-write hit flags let decode stall on a register that is
// still in flight.
// Optional feature macro: RF_ARB_FWD_EN adds qa_data/qb_data forwarding of the
// pending value (output stage first, then LNK, MEM, ALU; newest entry wins).
module rf_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    rf_write_arbiter_if.slave bus
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = PW + 1;
    localparam int NREQ = 3;

    typedef enum logic [1:0] {
        RR_ALU = 2'd0,
        RR_MEM = 2'd1,
        RR_LNK = 2'd2
    } rrSel_t;

    // FIFO control and storage, indexed by requester (ALU, MEM, LNK)
    logic [PW-1:0] wrPtr    [NREQ];
    logic [PW-1:0] rdPtr    [NREQ];
    logic [CW-1:0] count    [NREQ];
    logic [4:0]    fifoReg  [NREQ][DEPTH];
    logic [31:0]   fifoData [NREQ][DEPTH];

    logic          fifoReady [NREQ];
    logic          push      [NREQ];
    logic          pop       [NREQ];
    logic [4:0]    pushReg   [NREQ];
    logic [31:0]   pushData  [NREQ];

    // Round-robin pointer and grant
    rrSel_t        rr;
    rrSel_t        rrNext;
    rrSel_t        grantSel;
    logic          grantVld;
    logic [4:0]    headReg;
    logic [31:0]   headData;

    // Registered write-port stage
    logic          wrEn;
    logic [4:0]    wrReg;
    logic [31:0]   wrData;

    function automatic rrSel_t nextSel(input rrSel_t s);
        case (s)
            RR_ALU:  nextSel = RR_MEM;
            RR_MEM:  nextSel = RR_LNK;
            default: nextSel = RR_ALU;
        endcase
    endfunction

    // r0 is never reported: it is hard-wired and never really written.
    function automatic logic pendingHit(input logic [4:0] q);
        logic          hit;
        logic [PW-1:0] slot;
        hit = wrEn && (wrReg == q);
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot = rdPtr[i] + PW'(k);
                if ((CW'(k) < count[i]) && (fifoReg[i][slot] == q)) begin
                    hit = 1'b1;
                end
            end
        end
        return (q != 5'd0) && hit;
    endfunction

`ifdef RF_ARB_FWD_EN
    // Lowest priority is scanned first so later matches override earlier
    // ones: ALU < MEM < LNK < output stage, and within a FIFO oldest to
    // newest so the newest matching entry wins.
    function automatic logic [31:0] forwardData(input logic [4:0] q);
        logic [31:0]   d;
        logic [PW-1:0] slot;
        d = 32'd0;
        if (q != 5'd0) begin
            for (int i = 0; i < NREQ; i++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    slot = rdPtr[i] + PW'(k);
                    if ((CW'(k) < count[i]) && (fifoReg[i][slot] == q)) begin
                        d = fifoData[i][slot];
                    end
                end
            end
            if (wrEn && (wrReg == q)) begin
                d = wrData;
            end
        end
        return d;
    endfunction
`endif

    // Accept side: ready comes from the registered count only, and is held low in reset
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            fifoReady[i] = RST_N && (count[i] < CW'(DEPTH));
        end
        push[0]     = bus.alu_valid && fifoReady[0];
        push[1]     = bus.mem_valid && fifoReady[1];
        push[2]     = bus.lnk_valid && fifoReady[2];
        pushReg[0]  = bus.alu_reg;
        pushReg[1]  = bus.mem_reg;
        pushReg[2]  = 5'd31;
        pushData[0] = bus.alu_data;
        pushData[1] = bus.mem_data;
        pushData[2] = bus.lnk_pc + 32'd4;
    end

    assign bus.alu_ready = fifoReady[0];
    assign bus.mem_ready = fifoReady[1];
    assign bus.lnk_ready = fifoReady[2];

    // FIFO pointers and occupancy; a push and pop in the same cycle leave count unchanged
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREQ; i++) begin
                wrPtr[i] <= '0;
                rdPtr[i] <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (push[i]) begin
                    wrPtr[i] <= wrPtr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rdPtr[i] <= rdPtr[i] + PW'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
            end
        end
    end

    // FIFO payload storage; validity is tracked by the pointers, so no reset is needed
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                fifoReg[i][wrPtr[i]]  <= pushReg[i];
                fifoData[i][wrPtr[i]] <= pushData[i];
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr <= RR_ALU;
        end else begin
            rr <= rrNext;
        end
    end

    // Pointer advances past the grantee; an idle cycle leaves it where it is
    always_comb begin
        rrNext = rr;
        if (grantVld) begin
            rrNext = nextSel(grantSel);
        end
    end

    // Grant: first non-empty FIFO scanning ALU->MEM->LNK->ALU from rr
    always_comb begin
        rrSel_t sel;
        grantVld = 1'b0;
        grantSel = rr;
        sel      = rr;
        for (int k = 0; k < NREQ; k++) begin
            if (!grantVld && (count[sel] != '0)) begin
                grantVld = 1'b1;
                grantSel = sel;
            end
            sel = nextSel(sel);
        end
        for (int i = 0; i < NREQ; i++) begin
            pop[i] = grantVld && (int'(grantSel) == i);
        end
        headReg  = fifoReg[grantSel][rdPtr[grantSel]];
        headData = fifoData[grantSel][rdPtr[grantSel]];
    end

    // Write-port stage: a granted r0 entry still loads address/data but never asserts RegWr
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wrEn   <= 1'b0;
            wrReg  <= 5'd0;
            wrData <= 32'd0;
        end else begin
            wrEn <= grantVld && (headReg != 5'd0);
            if (grantVld) begin
                wrReg  <= headReg;
                wrData <= headData;
            end
        end
    end

    assign bus.RegWr     = wrEn;
    assign bus.WriteReg  = wrReg;
    assign bus.WriteData = wrData;

    // Hazard probe for both read ports, same cycle as the query
    always_comb begin
        bus.qa_hit = pendingHit(bus.qa_reg);
        bus.qb_hit = pendingHit(bus.qb_reg);
`ifdef RF_ARB_FWD_EN
        bus.qa_data = forwardData(bus.qa_reg);
        bus.qb_data = forwardData(bus.qb_reg);
`endif
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_rf_write_arbiter;
    localparam int DEPTH = 2;

    logic CLK;
    logic RST_N;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(.DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors;
    int checks;
    int cyc;

    // Reference model: one queue of {reg, data} per requester, a pointer,
    // and the expected write-port contents.
    logic [36:0] qAlu[$];
    logic [36:0] qMem[$];
    logic [36:0] qLnk[$];
    int          rrM;
    logic        expWr;
    logic [4:0]  expReg;
    logic [31:0] expData;

    // Observations taken before the clock edge of the last cycle
    logic        lastQaHit;
    logic        lastQbHit;
    logic [31:0] lastQbData;
    logic        lastAccA;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed=0x%08h expected=0x%08h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        qAlu.delete();
        qMem.delete();
        qLnk.delete();
        rrM     = 0;
        expWr   = 1'b0;
        expReg  = 5'd0;
        expData = 32'd0;
    endtask

    function automatic int qSize(input int i);
        case (i)
            0:       return qAlu.size();
            1:       return qMem.size();
            default: return qLnk.size();
        endcase
    endfunction

    task automatic qPop(input int i, output logic [36:0] e);
        case (i)
            0:       e = qAlu.pop_front();
            1:       e = qMem.pop_front();
            default: e = qLnk.pop_front();
        endcase
    endtask

    function automatic logic modelHit(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        if (expWr && expReg == q) return 1'b1;
        foreach (qAlu[k]) if (qAlu[k][36:32] == q) return 1'b1;
        foreach (qMem[k]) if (qMem[k][36:32] == q) return 1'b1;
        foreach (qLnk[k]) if (qLnk[k][36:32] == q) return 1'b1;
        return 1'b0;
    endfunction

`ifdef RF_ARB_FWD_EN
    function automatic logic [31:0] modelFwd(input logic [4:0] q);
        if (q == 5'd0) return 32'd0;
        if (expWr && expReg == q) return expData;
        for (int k = qLnk.size() - 1; k >= 0; k--) if (qLnk[k][36:32] == q) return qLnk[k][31:0];
        for (int k = qMem.size() - 1; k >= 0; k--) if (qMem[k][36:32] == q) return qMem[k][31:0];
        for (int k = qAlu.size() - 1; k >= 0; k--) if (qAlu[k][36:32] == q) return qAlu[k][31:0];
        return 32'd0;
    endfunction
`endif

    // One clock cycle: drive at negedge, check combinational outputs, advance
    // the model across the edge, then check the write port after the edge.
    task automatic cycle(input logic aV, input logic [4:0] aR, input logic [31:0] aD,
                         input logic mV, input logic [4:0] mR, input logic [31:0] mD,
                         input logic lV, input logic [31:0] lPc,
                         input logic [4:0] qa, input logic [4:0] qb);
        logic        accA, accM, accL;
        logic [36:0] e;
        int          g;
        @(negedge CLK);
        cyc++;
        bus.alu_valid = aV; bus.alu_reg = aR; bus.alu_data = aD;
        bus.mem_valid = mV; bus.mem_reg = mR; bus.mem_data = mD;
        bus.lnk_valid = lV; bus.lnk_pc  = lPc;
        bus.qa_reg    = qa; bus.qb_reg  = qb;
        #1;
        check("alu_ready", bus.alu_ready, qAlu.size() < DEPTH);
        check("mem_ready", bus.mem_ready, qMem.size() < DEPTH);
        check("lnk_ready", bus.lnk_ready, qLnk.size() < DEPTH);
        check("qa_hit", bus.qa_hit, modelHit(qa));
        check("qb_hit", bus.qb_hit, modelHit(qb));
        lastQaHit  = bus.qa_hit;
        lastQbHit  = bus.qb_hit;
        lastQbData = 32'd0;
`ifdef RF_ARB_FWD_EN
        check("qa_data", bus.qa_data, modelFwd(qa));
        check("qb_data", bus.qb_data, modelFwd(qb));
        lastQbData = bus.qb_data;
`endif
        lastAccA = aV && bus.alu_ready;
        accA = aV && (qAlu.size() < DEPTH);
        accM = mV && (qMem.size() < DEPTH);
        accL = lV && (qLnk.size() < DEPTH);
        g = -1;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (rrM + k) % 3;
            if (g < 0 && qSize(idx) > 0) g = idx;
        end
        if (g >= 0) begin
            qPop(g, e);
            expWr   = (e[36:32] != 5'd0);
            expReg  = e[36:32];
            expData = e[31:0];
            rrM     = (g + 1) % 3;
        end else begin
            expWr = 1'b0;
        end
        if (accA) qAlu.push_back({aR, aD});
        if (accM) qMem.push_back({mR, mD});
        if (accL) qLnk.push_back({5'd31, lPc + 32'd4});
        @(posedge CLK);
        #1;
        check("RegWr", bus.RegWr, expWr);
        check("WriteReg", bus.WriteReg, expReg);
        check("WriteData", bus.WriteData, expData);
    endtask

    task automatic idle(input logic [4:0] qa, input logic [4:0] qb);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, qa, qb);
    endtask

    initial begin
        int aluAcc;
        int aluWr;
        int aluWin;
        errors = 0;
        checks = 0;
        cyc    = 0;
        bus.alu_valid = 1'b0; bus.alu_reg = 5'd0; bus.alu_data = 32'd0;
        bus.mem_valid = 1'b0; bus.mem_reg = 5'd0; bus.mem_data = 32'd0;
        bus.lnk_valid = 1'b0; bus.lnk_pc  = 32'd0;
        bus.qa_reg    = 5'd5; bus.qb_reg  = 5'd31;
        modelReset();

        // Reset state
        RST_N = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        check("rst_alu_ready", bus.alu_ready, 0);
        check("rst_mem_ready", bus.mem_ready, 0);
        check("rst_lnk_ready", bus.lnk_ready, 0);
        check("rst_RegWr", bus.RegWr, 0);
        check("rst_WriteReg", bus.WriteReg, 0);
        check("rst_WriteData", bus.WriteData, 0);
        check("rst_qa_hit", bus.qa_hit, 0);
        check("rst_qb_hit", bus.qb_hit, 0);
`ifdef RF_ARB_FWD_EN
        check("rst_qa_data", bus.qa_data, 0);
        check("rst_qb_data", bus.qb_data, 0);
`endif
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // All three requesters push together: writes follow ALU, MEM, LNK
        cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b1, 32'h100, 5'd3, 5'd4);
        idle(5'd3, 5'd31);
        check("tri0_RegWr", bus.RegWr, 1);
        check("tri0_WriteReg", bus.WriteReg, 3);
        check("tri0_WriteData", bus.WriteData, 32'hA);
        idle(5'd4, 5'd31);
        check("tri1_WriteReg", bus.WriteReg, 4);
        check("tri1_WriteData", bus.WriteData, 32'hB);
        idle(5'd31, 5'd3);
        check("tri2_WriteReg", bus.WriteReg, 31);
        check("tri2_WriteData", bus.WriteData, 32'h104);
        idle(5'd3, 5'd4);
        check("tri_done_RegWr", bus.RegWr, 0);

        // Single ALU push: one-cycle latency, hit during the two pending cycles
        cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd5, 5'd0);
        check("single_hit_before", lastQaHit, 0);
        idle(5'd5, 5'd0);
        check("single_hit_fifo", lastQaHit, 1);
        check("single_RegWr", bus.RegWr, 1);
        check("single_WriteReg", bus.WriteReg, 5);
        check("single_WriteData", bus.WriteData, 32'h1234);
        idle(5'd5, 5'd0);
        check("single_hit_out", lastQaHit, 1);
        check("single_RegWr_off", bus.RegWr, 0);
        idle(5'd5, 5'd0);
        check("single_hit_after", lastQaHit, 0);

        // Write to r0 consumes a slot but never enables the write
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        check("r0_hit", lastQaHit, 0);
        check("r0_RegWr", bus.RegWr, 0);
        check("r0_WriteReg", bus.WriteReg, 0);
        check("r0_WriteData", bus.WriteData, 32'hFFFF_FFFF);

        // Link PC wrap
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 32'hFFFF_FFFC, 5'd31, 5'd0);
        idle(5'd31, 5'd0);
        check("lnk_hit", lastQaHit, 1);
        check("lnk_RegWr", bus.RegWr, 1);
        check("lnk_WriteReg", bus.WriteReg, 31);
        check("lnk_WriteData", bus.WriteData, 32'h0);

        // Continuous traffic from all three: ALU gets every third grant, nothing lost
        aluAcc = 0;
        aluWr  = 0;
        aluWin = 0;
        for (int n = 0; n < 12; n++) begin
            cycle(1'b1, 5'($urandom_range(1, 10)), $urandom,
                  1'b1, 5'($urandom_range(11, 20)), $urandom,
                  1'b1, $urandom, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
            if (lastAccA) aluAcc++;
            if (bus.RegWr && bus.WriteReg >= 5'd1 && bus.WriteReg <= 5'd10) begin
                aluWr++;
                if (n >= 3) aluWin++;
            end
        end
        check("starve_alu_share", aluWin, 3);
        for (int n = 0; n < 8; n++) begin
            idle(5'd1, 5'd11);
            if (bus.RegWr && bus.WriteReg >= 5'd1 && bus.WriteReg <= 5'd10) aluWr++;
        end
        check("starve_alu_no_loss", aluWr, aluAcc);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
                  5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7)));
        end
        for (int n = 0; n < 8; n++) idle(5'd7, 5'd31);

        // Two pending writes to r7 behind a LNK grant; newest value is forwarded
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 32'd0, 5'd9, 5'd0);
        idle(5'd9, 5'd0);
        cycle(1'b1, 5'd7, 32'd1, 1'b1, 5'd8, 32'h88, 1'b1, 32'h200, 5'd7, 5'd7);
        cycle(1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd8, 5'd7);
        idle(5'd8, 5'd7);
        check("fwd_qb_hit", lastQbHit, 1);
`ifdef RF_ARB_FWD_EN
        check("fwd_qb_data", lastQbData, 32'd2);
`endif

        // Reset in mid-drain: write port clears at once, pending entries vanish
        check("mid_RegWr_before", bus.RegWr, 1);
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_RegWr", bus.RegWr, 0);
        check("mid_rst_WriteReg", bus.WriteReg, 0);
        check("mid_rst_WriteData", bus.WriteData, 0);
        check("mid_rst_alu_ready", bus.alu_ready, 0);
        check("mid_rst_qb_hit", bus.qb_hit, 0);
        modelReset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        aluWr = 0;
        for (int n = 0; n < 5; n++) begin
            idle(5'd7, 5'd8);
            if (bus.RegWr) aluWr++;
        end
        check("mid_rst_no_writes", aluWr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
